spike_decoder: RTL
==================

Name: spike_decoder

Overview:
- Receive-side counterpart of the ECG delta-threshold spike encoder.
- Takes UP/DOWN spike streams plus the same delta step and rebuilds a piecewise-constant ECG estimate.
- Publishes the estimate once per sample period, together with per-period spike counts, for downstream SNN readout and debug.
- Shares the encoder's divided sample-rate notion: CLK_DIV fast clocks per sample tick.

Parameters:
- CLK_DIV, 1200000: fast clocks per sample tick; legal range >= 1.
- DEFAULT_LEVEL, 40: reconstruction level after reset. This is the midpoint of the encoder's default thresholds, 70 and 10.
- MIN_LEVEL, 0: lower saturation bound of the level.
- MAX_LEVEL, 32'hFFFF_FFFF: upper saturation bound of the level.
- CNT_W, 16: width of the per-period spike counters.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- spike_up_i  in  1  upper-threshold crossing spike; an event is its rising edge.
- spike_dn_i  in  1  lower-threshold crossing spike; an event is its rising edge.
- delta_i  in  32  step size, unsigned; sampled in the event cycle.
- ecg_o  out  32  reconstructed level, registered at each tick.
- ecg_valid_o  out  1  one-cycle pulse: ecg_o and the counters are fresh.
- up_cnt_o  out  CNT_W  UP events in the last completed period.
- dn_cnt_o  out  CNT_W  DOWN events in the last completed period.
- sat_o  out  1  sticky flag: a clamp occurred since reset.

Behaviour:
- Reset: asynchronous and active-high. One clock, clk_i; all state resets on rst_i.
- Reset values:
  - level_r = ecg_o = DEFAULT_LEVEL.
  - ecg_valid_o = 0, up_cnt_o = dn_cnt_o = 0, sat_o = 0.
  - Tick counter = 0, edge-detect previous-value registers = 0, window counters = 0.
  - A spike input held high when reset is released counts as one event on the first clock.
- Reset mid-period discards the partial period; there is no valid pulse for it.
- Edge detect: up_ev = spike_up_i & ~up_prev_r, and the same for dn_ev. A multi-cycle-high spike counts once.
- Level update, combinational level_next, registered every clock:
  - up_ev only: level_r + delta_i, computed in 33 bits, clamped to MAX_LEVEL.
  - dn_ev only: level_r - delta_i, computed as signed 33 bits, clamped to MIN_LEVEL.
  - Both, or neither: unchanged. Simultaneous events cancel, but both counters still increment.
  - delta_i = 0: an event still counts, and the level does not change.
  - A clamp sets sat_o. It stays set until reset.
- Tick:
  - The counter runs 0..CLK_DIV-1 and wraps.
  - tick = (cnt_r == CLK_DIV-1). With CLK_DIV = 1, tick is asserted every cycle.
- On the tick edge:
  - ecg_o <= level_next, including any event in the tick cycle.
  - up_cnt_o / dn_cnt_o <= window count plus the tick-cycle event.
  - Window counters clear to 0.
  - ecg_valid_o is high for exactly the following cycle.
- Latency: an event in cycle n appears in level_r at n+1. It appears on ecg_o at the first tick edge at or after n.
- Window counters saturate at 2^CNT_W-1 and never wrap.
- No handshake with the consumer. ecg_valid_o is a strobe, and ecg_o holds its value between ticks.

Decomposition:
- Shared package snn_pkg:
  - DATA_W = 32.
  - Default threshold constants, shared with the encoder.
  - A saturating add/sub function, sat_addsub(level, delta, dir, min, max), returning {value, clamped}.
- Sub-module spike_tick_gen (CLK_DIV): counter plus tick output.
  - The encoder's clock divider is refactored onto it later.
- Edge detect and counters stay inline.

Test Plan:
All scenarios use CLK_DIV = 4, DEFAULT_LEVEL = 40, MAX_LEVEL = 100 and MIN_LEVEL = 0 unless stated.
1. Reset release with no spikes, delta_i = 5 -> ecg_o = 40 on every tick. ecg_valid_o pulses every 4 cycles. Counters read 0.
2. Three separate 1-cycle UP pulses in one period, delta_i = 10 -> next ecg_o = 70, up_cnt_o = 3. Then one DOWN pulse -> ecg_o = 60, dn_cnt_o = 1, up_cnt_o = 0.
3. spike_up_i held high for 7 cycles -> exactly one event: level 40 -> 45 with delta_i = 5, up_cnt_o = 1.
4. Saturation, delta_i = 50:
   - UP x2 -> ecg_o = 100, sat_o = 1.
   - DOWN x3 -> ecg_o = 0.
   - sat_o stays 1.
5. UP and DOWN rising in the same cycle, delta_i = 9 -> level unchanged at 40, up_cnt_o = dn_cnt_o = 1.
6. Boundary cases:
   - UP event in the tick cycle is reflected in that tick's ecg_o.
   - rst_i asserted mid-period: outputs return to reset values asynchronously, with no valid pulse.
   - With CLK_DIV = 1, ecg_valid_o stays high every cycle and tracks level_next.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Constants and helpers shared by the ECG delta-threshold spike encoder and
// the spike decoder.
//   DATA_W        : width of ECG levels and delta steps
//   DEF_UPPER_THR : encoder default upper threshold
//   DEF_LOWER_THR : encoder default lower threshold
//   DEF_MID_LEVEL : midpoint of the two thresholds (decoder start level)
//   sat_addsub()  : one delta step up or down with clamping to [min, max];
//                   returns {value, clamped}
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] DEF_UPPER_THR = 32'd70;
  localparam logic [DATA_W-1:0] DEF_LOWER_THR = 32'd10;
  localparam logic [DATA_W-1:0] DEF_MID_LEVEL = (DEF_UPPER_THR + DEF_LOWER_THR) >> 1;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } step_dir_e;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              clamped;
  } sat_res_t;

  // Up steps are formed in DATA_W+1 unsigned bits so the carry is never lost;
  // down steps are formed as signed DATA_W+1 bits so an underflow shows up as
  // a negative number rather than a wrap.
  function automatic sat_res_t sat_addsub(
    input logic [DATA_W-1:0] level,
    input logic [DATA_W-1:0] delta,
    input step_dir_e         dir,
    input logic [DATA_W-1:0] min_v,
    input logic [DATA_W-1:0] max_v
  );
    logic        [DATA_W:0] sum;
    logic signed [DATA_W:0] diff;
    sat_res_t               res;
    res = '0;
    if (dir == DIR_UP) begin
      sum = {1'b0, level} + {1'b0, delta};
      if (sum > {1'b0, max_v}) begin
        res.value   = max_v;
        res.clamped = 1'b1;
      end else begin
        res.value   = sum[DATA_W-1:0];
        res.clamped = 1'b0;
      end
    end else begin
      diff = $signed({1'b0, level}) - $signed({1'b0, delta});
      if (diff < $signed({1'b0, min_v})) begin
        res.value   = min_v;
        res.clamped = 1'b1;
      end else begin
        res.value   = diff[DATA_W-1:0];
        res.clamped = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/spike_tick_gen.sv
// -----------------------------------------------------------------------------
// spike_tick_gen
// Sample-rate divider: a counter running 0..CLK_DIV-1 that wraps, with a
// tick on its last count. With CLK_DIV = 1 the tick is high every cycle.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset (counter -> 0)
//   tick_o : high during the last fast clock of each sample period
// -----------------------------------------------------------------------------
module spike_tick_gen #(
  parameter int unsigned CLK_DIV = 1200000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick_o = (cnt_r == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (tick_o) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/spike_decoder.sv
// -----------------------------------------------------------------------------
// spike_decoder
// Receive-side counterpart of the ECG delta-threshold spike encoder. Rising
// edges on the UP/DOWN spike lines step a reconstruction level by delta_i
// (clamped to [MIN_LEVEL, MAX_LEVEL]); once per sample period the level and
// the period's event counts are published with a one-cycle valid strobe.
//   clk_i       : system clock
//   rst_i       : asynchronous active-high reset
//   spike_up_i  : upper-threshold spike, event = rising edge
//   spike_dn_i  : lower-threshold spike, event = rising edge
//   delta_i     : unsigned step size, sampled in the event cycle
//   ecg_o       : reconstructed level, updated at each tick edge
//   ecg_valid_o : one-cycle strobe after each tick edge
//   up_cnt_o    : UP events in the last completed period
//   dn_cnt_o    : DOWN events in the last completed period
//   sat_o       : sticky, a clamp has occurred since reset
// -----------------------------------------------------------------------------
module spike_decoder
  import snn_pkg::*;
#(
  parameter int unsigned       CLK_DIV       = 1200000,
  parameter logic [DATA_W-1:0] DEFAULT_LEVEL = DEF_MID_LEVEL,
  parameter logic [DATA_W-1:0] MIN_LEVEL     = '0,
  parameter logic [DATA_W-1:0] MAX_LEVEL     = 32'hFFFF_FFFF,
  parameter int                CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spike_up_i,
  input  logic              spike_dn_i,
  input  logic [DATA_W-1:0] delta_i,
  output logic [DATA_W-1:0] ecg_o,
  output logic              ecg_valid_o,
  output logic [CNT_W-1:0]  up_cnt_o,
  output logic [CNT_W-1:0]  dn_cnt_o,
  output logic              sat_o
);

  logic              up_prev_r;
  logic              dn_prev_r;
  logic              up_ev;
  logic              dn_ev;
  logic              tick;
  logic [DATA_W-1:0] level_r;
  logic [DATA_W-1:0] level_next;
  logic              step_clamp;
  sat_res_t          step_res;
  logic [CNT_W-1:0]  win_up_r;
  logic [CNT_W-1:0]  win_dn_r;
  logic [CNT_W-1:0]  win_up_next;
  logic [CNT_W-1:0]  win_dn_next;

  // Window counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             inc
  );
    if (inc && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  spike_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign up_ev = spike_up_i & ~up_prev_r;
  assign dn_ev = spike_dn_i & ~dn_prev_r;

  // Simultaneous UP and DOWN cancel; only a lone event moves the level.
  always_comb begin
    level_next = level_r;
    step_clamp = 1'b0;
    step_res   = '0;
    if (up_ev ^ dn_ev) begin
      step_res   = sat_addsub(level_r, delta_i, up_ev ? DIR_UP : DIR_DN,
                              MIN_LEVEL, MAX_LEVEL);
      level_next = step_res.value;
      step_clamp = step_res.clamped;
    end
  end

  // Counts including the current cycle's event, so a tick-cycle event lands
  // in the period that is being closed.
  assign win_up_next = cnt_sat_inc(win_up_r, up_ev);
  assign win_dn_next = cnt_sat_inc(win_dn_r, dn_ev);

  // ---- register stage: edge detect, level, window, published outputs ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_prev_r   <= 1'b0;
      dn_prev_r   <= 1'b0;
      level_r     <= DEFAULT_LEVEL;
      win_up_r    <= '0;
      win_dn_r    <= '0;
      ecg_o       <= DEFAULT_LEVEL;
      ecg_valid_o <= 1'b0;
      up_cnt_o    <= '0;
      dn_cnt_o    <= '0;
      sat_o       <= 1'b0;
    end else begin
      up_prev_r   <= spike_up_i;
      dn_prev_r   <= spike_dn_i;
      level_r     <= level_next;
      sat_o       <= sat_o | step_clamp;
      ecg_valid_o <= tick;
      if (tick) begin
        ecg_o    <= level_next;
        up_cnt_o <= win_up_next;
        dn_cnt_o <= win_dn_next;
        win_up_r <= '0;
        win_dn_r <= '0;
      end else begin
        win_up_r <= win_up_next;
        win_dn_r <= win_dn_next;
      end
    end
  end

endmodule
